// File: rtl/mem_port_arbiter_pkg.sv
// Shared constants, state encoding and helpers for the main-memory port arbiter.
// Requester 0 is the D-cache miss engine, requester 1 the I-cache miss engine.
package mem_port_arbiter_pkg;

    localparam int LINE_ADDR_LEN = 3;
    localparam int LINE_WORDS    = 1 << LINE_ADDR_LEN;
    localparam int ADDR_W        = 32;
    localparam int DATA_W        = 32;
    localparam int BASE_W        = ADDR_W - LINE_ADDR_LEN - 2;

    localparam int RQ_D = 0;
    localparam int RQ_I = 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1,
        ST_DONE = 2'd2
    } arb_state_e;

    typedef logic [LINE_ADDR_LEN-1:0] word_idx_t;

    function automatic logic [DATA_W-1:0] pick_word(input logic [2*DATA_W-1:0] words, input logic sel);
        pick_word = sel ? words[DATA_W +: DATA_W] : words[0 +: DATA_W];
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the requester-side and memory-side signals of the memory port arbiter.
// The slave modport is the arbiter's view; master is the surrounding caches and memory.
interface mem_port_arbiter_if;
    import mem_port_arbiter_pkg::*;

    logic [1:0]               rq_req;
    logic [1:0]               rq_we;
    logic [2*ADDR_W-1:0]      rq_addr;
    logic [2*DATA_W-1:0]      rq_wdata;
    logic [1:0]               gnt;
    logic [LINE_ADDR_LEN-1:0] wd_idx;
    logic [DATA_W-1:0]        rd_data;
    logic [1:0]               rd_valid;
    logic [1:0]               rq_done;
    logic [1:0]               busy;
    logic                     mem_req;
    logic                     mem_we;
    logic [ADDR_W-1:0]        mem_addr;
    logic [DATA_W-1:0]        mem_wdata;
    logic [DATA_W-1:0]        mem_rdata;
    logic                     mem_ack;

    modport slave (
        input  rq_req, rq_we, rq_addr, rq_wdata, mem_rdata, mem_ack,
        output gnt, wd_idx, rd_data, rd_valid, rq_done, busy,
               mem_req, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output rq_req, rq_we, rq_addr, rq_wdata, mem_rdata, mem_ack,
        input  gnt, wd_idx, rd_data, rd_valid, rq_done, busy,
               mem_req, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/mem_port_arbiter_rr_arbiter2.sv
// Two-way round-robin pick between D-cache and I-cache requests.
// A lone requester wins; a tie goes to whichever was not served last.
module rr_arbiter2
    import mem_port_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       upd,
    output logic [1:0] win
);

    logic last_gnt_r;

    // Winner selection from the current request pair and the last grant.
    always_comb begin
        win = 2'b00;
        case (req)
            2'b01:   win = 2'b01;
            2'b10:   win = 2'b10;
            2'b11:   win = last_gnt_r ? 2'b01 : 2'b10;
            default: win = 2'b00;
        endcase
    end

    // Last-served memory; starts at the I-cache so the D-cache wins the first tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_gnt_r <= 1'b1;
        end else if (upd && (req != 2'b00)) begin
            last_gnt_r <= win[RQ_I];
        end else begin
            last_gnt_r <= last_gnt_r;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the main-memory port between the D-cache and I-cache miss engines and
// sequences one full line burst per grant over the mem_req/mem_ack word handshake.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    mem_port_arbiter_if.slave bus
);

    arb_state_e         state_r;
    arb_state_e         state_nxt_s;
    logic [1:0]         win_s;
    logic [1:0]         gnt_r;
    logic [1:0]         rd_valid_r;
    logic [1:0]         rq_done_r;
    logic [1:0]         busy_s;
    word_idx_t          wd_idx_r;
    logic [BASE_W-1:0]  base_r;
    logic               mem_req_r;
    logic               mem_we_r;
    logic [DATA_W-1:0]  rd_data_r;
    logic [ADDR_W-1:0]  mem_addr_s;
    logic [DATA_W-1:0]  mem_wdata_s;
    logic               grant_s;
    logic               word_ack_s;
    logic               reissue_s;
    logic               last_word_s;

    rr_arbiter2 u_rr (
        .clk (clk),
        .rst (rst),
        .req (bus.rq_req),
        .upd (grant_s),
        .win (win_s)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic: arbitrate in IDLE, leave XFER on the last word's ack.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (grant_s) begin
                    state_nxt_s = ST_XFER;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_XFER: begin
                if (word_ack_s && last_word_s) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_XFER;
                end
            end
            ST_DONE: state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Output decode: per-state events plus the combinational address/data/stall paths.
    always_comb begin
        grant_s    = 1'b0;
        word_ack_s = 1'b0;
        reissue_s  = 1'b0;
        case (state_r)
            ST_IDLE: grant_s = (bus.rq_req != 2'b00);
            ST_XFER: begin
                // mem_ack only counts against an outstanding word request
                word_ack_s = mem_req_r & bus.mem_ack;
                reissue_s  = ~mem_req_r;
            end
            ST_DONE: grant_s = 1'b0;
            default: grant_s = 1'b0;
        endcase
        last_word_s = (wd_idx_r == word_idx_t'(LINE_WORDS - 1));
        mem_addr_s  = {base_r, wd_idx_r, 2'b00};
        mem_wdata_s = pick_word(bus.rq_wdata, gnt_r[RQ_I]);
        busy_s      = bus.rq_req | gnt_r;
    end

    // Burst datapath: grant latch, word index, request handshake and response pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            gnt_r      <= 2'b00;
            wd_idx_r   <= {LINE_ADDR_LEN{1'b0}};
            base_r     <= {BASE_W{1'b0}};
            mem_req_r  <= 1'b0;
            mem_we_r   <= 1'b0;
            rd_data_r  <= {DATA_W{1'b0}};
            rd_valid_r <= 2'b00;
            rq_done_r  <= 2'b00;
        end else begin
            rd_valid_r <= 2'b00;
            rq_done_r  <= 2'b00;
            if (grant_s) begin
                gnt_r     <= win_s;
                base_r    <= win_s[RQ_I] ? bus.rq_addr[ADDR_W + LINE_ADDR_LEN + 2 +: BASE_W]
                                         : bus.rq_addr[LINE_ADDR_LEN + 2 +: BASE_W];
                mem_we_r  <= win_s[RQ_I] ? bus.rq_we[RQ_I] : bus.rq_we[RQ_D];
                wd_idx_r  <= {LINE_ADDR_LEN{1'b0}};
                mem_req_r <= 1'b1;
            end else if (word_ack_s) begin
                // wd_idx holds through the gap cycle so rd_valid reports the acked word
                mem_req_r <= 1'b0;
                if (!mem_we_r) begin
                    rd_data_r  <= bus.mem_rdata;
                    rd_valid_r <= gnt_r;
                end else begin
                    rd_data_r  <= rd_data_r;
                end
                if (last_word_s) begin
                    rq_done_r <= gnt_r;
                end else begin
                    rq_done_r <= 2'b00;
                end
            end else if (reissue_s) begin
                mem_req_r <= 1'b1;
                wd_idx_r  <= wd_idx_r + word_idx_t'(1);
            end else if (state_r == ST_DONE) begin
                gnt_r    <= 2'b00;
                mem_we_r <= 1'b0;
            end else begin
                gnt_r <= gnt_r;
            end
        end
    end

    assign bus.gnt       = gnt_r;
    assign bus.wd_idx    = wd_idx_r;
    assign bus.rd_data   = rd_data_r;
    assign bus.rd_valid  = rd_valid_r;
    assign bus.rq_done   = rq_done_r;
    assign bus.busy      = busy_s;
    assign bus.mem_req   = mem_req_r;
    assign bus.mem_we    = mem_we_r;
    assign bus.mem_addr  = mem_addr_s;
    assign bus.mem_wdata = mem_wdata_s;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: randomized requests and memory latency, checked against
// a line-transfer model (round-robin order, 8 words per burst, address/data arithmetic).
module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;

    typedef struct packed { logic we; logic [31:0] addr; logic [31:0] wdata; logic [1:0] gnt; } mem_ev_t;
    typedef struct packed { logic [1:0] v; logic [2:0] idx; logic [31:0] data; } rd_ev_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_port_arbiter_if bus();
    mem_port_arbiter dut (.clk(clk), .rst(rst), .bus(bus));

    int checks = 0;
    int failures = 0;
    int ack_mode = 0;
    int ack_delay = 2;
    int cyc = 0;
    int gnt_bad = 0;
    int model_last = 1;
    logic [1:0]  prev_gnt = 2'b00;
    logic [31:0] salt = 32'h0;
    logic [31:0] wbase [2];

    mem_ev_t    mem_log[$], exp_mem[$];
    rd_ev_t     rd_log[$],  exp_rd[$];
    logic [1:0] done_log[$], exp_done[$], gnt_log[$];
    int         done_cyc[$], gnt_cyc[$];

    assign bus.rq_wdata = {wbase[1] + 32'(bus.wd_idx), wbase[0] + 32'(bus.wd_idx)};

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ salt;
    endfunction

    // Model of one line transfer: 8 words at base+4k, refill data from memory, one done pulse.
    function automatic void expect_burst(input int n, input logic [31:0] addr, input logic we);
        logic [31:0] b;
        logic [1:0]  g;
        b = {addr[31:5], 5'b00000};
        g = (n == 1) ? 2'b10 : 2'b01;
        for (int k = 0; k < 8; k++) begin
            exp_mem.push_back(mem_ev_t'{we, b + 32'(4 * k), wbase[n] + 32'(k), g});
            if (!we) exp_rd.push_back(rd_ev_t'{g, 3'(k), mem_word(b + 32'(4 * k))});
        end
        exp_done.push_back(g);
    endfunction

    // Memory responder: ack after a delay (0 fixed, 1 tied high, 2 random 0..3).
    initial begin
        int wait_cnt;
        int d;
        wait_cnt = 0;
        d = 0;
        bus.mem_ack = 1'b0;
        bus.mem_rdata = 32'h0;
        forever begin
            @(negedge clk);
            if (ack_mode == 1) begin
                bus.mem_ack = 1'b1;
                bus.mem_rdata = mem_word(bus.mem_addr);
            end else if (bus.mem_ack) begin
                bus.mem_ack = 1'b0;
                wait_cnt = 0;
                d = (ack_mode == 2) ? int'($urandom_range(0, 3)) : ack_delay;
            end else if (bus.mem_req) begin
                if (wait_cnt >= d) begin
                    bus.mem_ack = 1'b1;
                    bus.mem_rdata = mem_word(bus.mem_addr);
                end else begin
                    wait_cnt++;
                end
            end else begin
                wait_cnt = 0;
                d = (ack_mode == 2) ? int'($urandom_range(0, 3)) : ack_delay;
            end
        end
    end

    // One clock: requesters drop rq_req on their done pulse, then observations are logged.
    task automatic tick();
        @(negedge clk);
        bus.rq_req = bus.rq_req & ~bus.rq_done;
        #2;
        cyc++;
        if (bus.mem_req && bus.mem_ack) mem_log.push_back(mem_ev_t'{bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.gnt});
        if (bus.rd_valid != 2'b00) rd_log.push_back(rd_ev_t'{bus.rd_valid, bus.wd_idx, bus.rd_data});
        if (bus.rq_done != 2'b00) begin done_log.push_back(bus.rq_done); done_cyc.push_back(cyc); end
        if (bus.gnt != 2'b00 && prev_gnt == 2'b00) begin gnt_log.push_back(bus.gnt); gnt_cyc.push_back(cyc); end
        if (bus.gnt == 2'b11) gnt_bad++;
        prev_gnt = bus.gnt;
        #1;
    endtask

    task automatic clear_logs();
        mem_log.delete(); exp_mem.delete(); rd_log.delete(); exp_rd.delete();
        done_log.delete(); exp_done.delete(); gnt_log.delete(); done_cyc.delete(); gnt_cyc.delete();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.rq_req = 2'b00;
        ack_mode = 0;
        ack_delay = 2;
        tick();
        tick();
        rst = 1'b0;
        model_last = 1;
        clear_logs();
    endtask

    task automatic wait_done(input int n, input int budget);
        for (int i = 0; i < budget && done_log.size() < n; i++) tick();
    endtask

    task automatic test_reset();
        do_reset();
        tick();
        checks++; if (bus.gnt !== 2'b00) begin failures++; $display("FAIL reset_gnt got %b want 00", bus.gnt); end
        checks++; if (bus.wd_idx !== 3'd0) begin failures++; $display("FAIL reset_wd_idx got %0d want 0", bus.wd_idx); end
        checks++; if (bus.mem_req !== 1'b0 || bus.mem_we !== 1'b0) begin failures++; $display("FAIL reset_mem got req=%b we=%b want 0 0", bus.mem_req, bus.mem_we); end
        checks++; if (bus.rd_valid !== 2'b00 || bus.rq_done !== 2'b00) begin failures++; $display("FAIL reset_pulses got rv=%b done=%b want 00 00", bus.rd_valid, bus.rq_done); end
        checks++; if (bus.busy !== 2'b00) begin failures++; $display("FAIL reset_busy got %b want 00", bus.busy); end
    endtask

    task automatic test_refill();
        do_reset();
        bus.rq_we = 2'b00;
        bus.rq_addr = {32'h0000_8000, 32'h0000_1040};
        expect_burst(0, 32'h0000_1040, 1'b0);
        bus.rq_req = 2'b01;
        wait_done(1, 300);
        checks++;
        if (mem_log.size() != exp_mem.size()) begin failures++; $display("FAIL refill_words got %0d want %0d", mem_log.size(), exp_mem.size()); end
        else for (int k = 0; k < mem_log.size(); k++) begin
            checks++;
            if (mem_log[k].we !== 1'b0 || mem_log[k].addr !== exp_mem[k].addr || mem_log[k].gnt !== 2'b01) begin
                failures++; $display("FAIL refill_word%0d got we=%b addr=%h gnt=%b want 0 %h 01", k, mem_log[k].we, mem_log[k].addr, mem_log[k].gnt, exp_mem[k].addr);
            end
        end
        checks++;
        if (rd_log.size() != exp_rd.size()) begin failures++; $display("FAIL refill_rdvalid got %0d want %0d", rd_log.size(), exp_rd.size()); end
        else for (int k = 0; k < rd_log.size(); k++) begin
            checks++;
            if (rd_log[k] !== exp_rd[k]) begin failures++; $display("FAIL refill_rd%0d got %h want %h", k, rd_log[k], exp_rd[k]); end
        end
        checks++;
        if (done_log.size() != 1 || done_log[0] !== 2'b01 || gnt_log.size() != 1 || gnt_log[0] !== 2'b01) begin
            failures++; $display("FAIL refill_done got dones=%0d grants=%0d want 1 1 for 01", done_log.size(), gnt_log.size());
        end
    endtask

    task automatic test_alternation();
        int first;
        do_reset();
        ack_mode = 2;
        bus.rq_we = 2'b00;
        for (int r = 0; r < 4; r++) begin
            tick();
            done_log.delete();
            bus.rq_addr = {$urandom, $urandom};
            first = (model_last == 1) ? 0 : 1;
            model_last = 1 - first;
            bus.rq_req = 2'b11;
            wait_done(2, 500);
            checks++;
            if (done_log.size() != 2 || done_log[0] !== ((first == 1) ? 2'b10 : 2'b01) || done_log[1] !== ((first == 1) ? 2'b01 : 2'b10)) begin
                failures++; $display("FAIL alternation_round%0d got %0d dones first=%b want first requester %0d", r, done_log.size(), (done_log.size() > 0) ? done_log[0] : 2'b00, first);
            end
        end
        checks++; if (gnt_bad != 0) begin failures++; $display("FAIL gnt_onehot got %0d two-hot cycles want 0", gnt_bad); end
    endtask

    task automatic test_writeback();
        do_reset();
        bus.rq_we = 2'b01;
        bus.rq_addr = {32'h0000_9000, 32'h0000_2000};
        wbase[0] = 32'h0000_00A0;
        expect_burst(0, 32'h0000_2000, 1'b1);
        bus.rq_req = 2'b01;
        wait_done(1, 300);
        checks++;
        if (mem_log.size() != exp_mem.size()) begin failures++; $display("FAIL wb_words got %0d want %0d", mem_log.size(), exp_mem.size()); end
        else for (int k = 0; k < mem_log.size(); k++) begin
            checks++;
            if (mem_log[k] !== exp_mem[k]) begin
                failures++; $display("FAIL wb_word%0d got we=%b addr=%h wdata=%h want we=1 addr=%h wdata=%h", k, mem_log[k].we, mem_log[k].addr, mem_log[k].wdata, exp_mem[k].addr, exp_mem[k].wdata);
            end
        end
        checks++; if (rd_log.size() != 0) begin failures++; $display("FAIL wb_no_rdvalid got %0d pulses want 0", rd_log.size()); end
    endtask

    task automatic test_contention();
        do_reset();
        bus.rq_we = 2'b00;
        bus.rq_addr = {32'h0000_4400, 32'h0000_4000};
        bus.rq_req = 2'b01;
        for (int i = 0; i < 200 && !(bus.gnt == 2'b01 && bus.wd_idx == 3'd3); i++) tick();
        bus.rq_req = 2'b11;
        tick();
        checks++; if (bus.gnt !== 2'b01) begin failures++; $display("FAIL contend_gnt got %b want 01", bus.gnt); end
        checks++; if (bus.busy !== 2'b11) begin failures++; $display("FAIL contend_busy got %b want 11", bus.busy); end
        wait_done(2, 500);
        checks++;
        if (done_log.size() != 2 || done_log[0] !== 2'b01 || done_log[1] !== 2'b10) begin
            failures++; $display("FAIL contend_order got %0d dones want D then I", done_log.size());
        end
        checks++;
        if (gnt_cyc.size() != 2 || done_cyc.size() < 1 || gnt_cyc[1] - done_cyc[0] != 2) begin
            failures++; $display("FAIL contend_regrant got grants=%0d gap=%0d want 2 grants gap 2", gnt_cyc.size(), (gnt_cyc.size() == 2 && done_cyc.size() > 0) ? gnt_cyc[1] - done_cyc[0] : -1);
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        ack_delay = 1;
        bus.rq_we = 2'b00;
        bus.rq_addr = {32'h0000_7000, 32'h0000_5000};
        bus.rq_req = 2'b01;
        for (int i = 0; i < 300 && !(bus.wd_idx == 3'd5 && bus.mem_req); i++) tick();
        checks++; if (bus.wd_idx !== 3'd5) begin failures++; $display("FAIL midrst_reach got wd_idx=%0d want 5", bus.wd_idx); end
        rst = 1'b1;
        bus.rq_req = 2'b00;
        tick();
        checks++; if (bus.mem_req !== 1'b0 || bus.gnt !== 2'b00) begin failures++; $display("FAIL midrst_abort got req=%b gnt=%b want 0 00", bus.mem_req, bus.gnt); end
        rst = 1'b0;
        model_last = 1;
        repeat (5) tick();
        checks++; if (done_log.size() != 0) begin failures++; $display("FAIL midrst_nodone got %0d want 0", done_log.size()); end
        clear_logs();
        bus.rq_addr = {32'h0000_7000, 32'h0000_3000};
        bus.rq_req = 2'b01;
        wait_done(1, 300);
        checks++;
        if (mem_log.size() != 8 || mem_log[0].addr !== 32'h0000_3000 || rd_log.size() != 8 || rd_log[0].idx !== 3'd0) begin
            failures++; $display("FAIL midrst_restart got words=%0d first=%h reads=%0d want 8 00003000 8", mem_log.size(), (mem_log.size() > 0) ? mem_log[0].addr : 32'h0, rd_log.size());
        end
    endtask

    task automatic test_ack_tied();
        int span;
        do_reset();
        ack_mode = 1;
        bus.rq_we = 2'b00;
        bus.rq_addr = {32'h0000_7700, 32'h0000_6660};
        bus.rq_req = 2'b01;
        wait_done(1, 100);
        span = (done_cyc.size() == 1 && gnt_cyc.size() == 1) ? done_cyc[0] - gnt_cyc[0] : -1;
        checks++; if (span < 15 || span > 18) begin failures++; $display("FAIL tied_span got %0d want 15..18", span); end
        checks++; if (mem_log.size() != 8 || rd_log.size() != 8) begin failures++; $display("FAIL tied_words got %0d/%0d want 8/8", mem_log.size(), rd_log.size()); end
        ack_mode = 0;
        tick();
        tick();
    endtask

    task automatic test_random();
        int m, first, nb;
        do_reset();
        ack_mode = 2;
        for (int r = 0; r < 8; r++) begin
            tick();
            tick();
            clear_logs();
            m = int'($urandom_range(1, 3));
            bus.rq_we = 2'($urandom);
            bus.rq_addr = {$urandom, $urandom};
            wbase[0] = $urandom;
            wbase[1] = $urandom;
            first = (m == 3) ? ((model_last == 1) ? 0 : 1) : ((m == 2) ? 1 : 0);
            expect_burst(first, bus.rq_addr[first * 32 +: 32], bus.rq_we[first]);
            model_last = first;
            nb = 1;
            if (m == 3) begin
                expect_burst(1 - first, bus.rq_addr[(1 - first) * 32 +: 32], bus.rq_we[1 - first]);
                model_last = 1 - first;
                nb = 2;
            end
            bus.rq_req = 2'(m);
            wait_done(nb, 800);
            checks++;
            if (mem_log.size() != exp_mem.size()) begin failures++; $display("FAIL rand%0d_words got %0d want %0d", r, mem_log.size(), exp_mem.size()); end
            else for (int k = 0; k < mem_log.size(); k++) begin
                checks++;
                if (mem_log[k].we !== exp_mem[k].we || mem_log[k].addr !== exp_mem[k].addr || mem_log[k].gnt !== exp_mem[k].gnt ||
                    (exp_mem[k].we && mem_log[k].wdata !== exp_mem[k].wdata)) begin
                    failures++; $display("FAIL rand%0d_word%0d got %h want %h", r, k, mem_log[k], exp_mem[k]);
                end
            end
            checks++;
            if (rd_log.size() != exp_rd.size()) begin failures++; $display("FAIL rand%0d_reads got %0d want %0d", r, rd_log.size(), exp_rd.size()); end
            else for (int k = 0; k < rd_log.size(); k++) begin
                checks++;
                if (rd_log[k] !== exp_rd[k]) begin failures++; $display("FAIL rand%0d_rd%0d got %h want %h", r, k, rd_log[k], exp_rd[k]); end
            end
            checks++;
            if (done_log.size() != exp_done.size() || done_log[0] !== exp_done[0]) begin
                failures++; $display("FAIL rand%0d_done got %0d dones want %0d first %b", r, done_log.size(), exp_done.size(), exp_done[0]);
            end
        end
        checks++; if (gnt_bad != 0) begin failures++; $display("FAIL rand_gnt_onehot got %0d want 0", gnt_bad); end
    endtask

    initial begin
        bus.rq_req = 2'b00;
        bus.rq_we = 2'b00;
        bus.rq_addr = 64'h0;
        wbase[0] = 32'h0;
        wbase[1] = 32'h0;
        salt = $urandom;
        test_reset();
        test_refill();
        test_alternation();
        test_writeback();
        test_contention();
        test_mid_reset();
        test_ack_tied();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
